// File: rtl/rs_pkg.sv
// Shared reservation-station types and default sizing, used by the RS issue
// logic and its allocator companion.
package rs_pkg;

  localparam int unsigned RS_SIZE_DEF        = 4;
  localparam int unsigned RS_INDEX_WIDTH_DEF = 2;
  localparam int unsigned AGE_WIDTH_DEF      = 3;

  typedef logic [RS_INDEX_WIDTH_DEF-1:0] rs_idx_t;
  typedef logic [AGE_WIDTH_DEF-1:0]      rs_age_t;

  typedef struct packed {
    logic    valid;
    logic    rdy;
    logic    picked;
    rs_age_t age;
  } rs_entry_state_t;

endpackage

// File: rtl/rs_pick2.sv
// Combinational pick-two over the RS candidate vector.
// RS_AGE_ORDER_EN defined: oldest first (highest age, ties to lowest index).
// RS_AGE_ORDER_EN undefined: lowest index first, then next lowest.
module rs_pick2 #(
  parameter int unsigned RS_SIZE        = 4,
  parameter int unsigned RS_INDEX_WIDTH = 2
`ifdef RS_AGE_ORDER_EN
  ,
  parameter int unsigned AGE_WIDTH      = 3
`endif
) (
  input  logic [RS_SIZE-1:0]                cand,
`ifdef RS_AGE_ORDER_EN
  input  logic [RS_SIZE-1:0][AGE_WIDTH-1:0] ages,
`endif
  output logic                              first_found,
  output logic [RS_INDEX_WIDTH-1:0]         first_index,
  output logic                              second_found,
  output logic [RS_INDEX_WIDTH-1:0]         second_index
);

`ifdef RS_AGE_ORDER_EN
  logic [AGE_WIDTH-1:0] best_age;

  // Two oldest-first scans; strict '>' keeps the lowest index on equal ages.
  always_comb begin
    first_found  = 1'b0;
    first_index  = '0;
    second_found = 1'b0;
    second_index = '0;
    best_age     = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (cand[i] && (!first_found || ages[i] > best_age)) begin
        first_found = 1'b1;
        first_index = RS_INDEX_WIDTH'(i);
        best_age    = ages[i];
      end
    end
    best_age = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (cand[i] && !(first_found && first_index == RS_INDEX_WIDTH'(i)) &&
          (!second_found || ages[i] > best_age)) begin
        second_found = 1'b1;
        second_index = RS_INDEX_WIDTH'(i);
        best_age     = ages[i];
      end
    end
  end
`else
  // Ascending scan: first candidate seen, then the next one.
  always_comb begin
    first_found  = 1'b0;
    first_index  = '0;
    second_found = 1'b0;
    second_index = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (cand[i]) begin
        if (!first_found) begin
          first_found = 1'b1;
          first_index = RS_INDEX_WIDTH'(i);
        end else if (!second_found) begin
          second_found = 1'b1;
          second_index = RS_INDEX_WIDTH'(i);
        end
      end
    end
  end
`endif

endmodule

// File: rtl/rs_issue_select.sv
// RS issue select: per-entry valid/ready/picked(/age) state, two write ports,
// wakeup, and two registered issue slots with valid/ready handshakes.
// Optional RS_AGE_ORDER_EN: oldest-first picking with per-entry age counters.
module rs_issue_select
  import rs_pkg::*;
#(
  parameter int unsigned RS_SIZE        = RS_SIZE_DEF,
  parameter int unsigned RS_INDEX_WIDTH = RS_INDEX_WIDTH_DEF,
  parameter int unsigned AGE_WIDTH      = AGE_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush_i,
  input  logic                      wr_first_en_i,
  input  logic [RS_INDEX_WIDTH-1:0] wr_first_index_i,
  input  logic                      wr_first_ready_i,
  input  logic                      wr_second_en_i,
  input  logic [RS_INDEX_WIDTH-1:0] wr_second_index_i,
  input  logic                      wr_second_ready_i,
  input  logic [RS_SIZE-1:0]        wakeup_i,
  output logic [RS_SIZE-1:0]        rs_unused_o,
  output logic                      issue_first_valid_o,
  output logic [RS_INDEX_WIDTH-1:0] issue_first_index_o,
  input  logic                      issue_first_ready_i,
  output logic                      issue_second_valid_o,
  output logic [RS_INDEX_WIDTH-1:0] issue_second_index_o,
  input  logic                      issue_second_ready_i
);

  logic [RS_SIZE-1:0]        entry_valid, entry_rdy, entry_picked;
  logic [RS_SIZE-1:0]        cand, wr_hit, wr_rdy, fire_hit, load_hit;
  logic                      slot0_valid, slot1_valid;
  logic [RS_INDEX_WIDTH-1:0] slot0_index, slot1index_q;
  logic                      fire0, fire1, avail0, avail1;
  logic                      pick0_found, pick1_found;
  logic [RS_INDEX_WIDTH-1:0] pick0_index, pick1_index;
  logic                      load0, load1;
  logic [RS_INDEX_WIDTH-1:0] load1_index;

  assign cand   = entry_valid & entry_rdy & ~entry_picked;
  assign fire0  = slot0_valid & issue_first_ready_i;
  assign fire1  = slot1_valid & issue_second_ready_i;
  assign avail0 = !slot0_valid | issue_first_ready_i;
  assign avail1 = !slot1_valid | issue_second_ready_i;

`ifdef RS_AGE_ORDER_EN
  logic [RS_SIZE-1:0][AGE_WIDTH-1:0] entry_age;

  rs_pick2 #(
    .RS_SIZE        (RS_SIZE),
    .RS_INDEX_WIDTH (RS_INDEX_WIDTH),
    .AGE_WIDTH      (AGE_WIDTH)
  ) u_pick2 (
    .cand         (cand),
    .ages         (entry_age),
    .first_found  (pick0_found),
    .first_index  (pick0_index),
    .second_found (pick1_found),
    .second_index (pick1_index)
  );
`else
  rs_pick2 #(
    .RS_SIZE        (RS_SIZE),
    .RS_INDEX_WIDTH (RS_INDEX_WIDTH)
  ) u_pick2 (
    .cand         (cand),
    .first_found  (pick0_found),
    .first_index  (pick0_index),
    .second_found (pick1_found),
    .second_index (pick1_index)
  );
`endif

  // Slot 0 always takes the first pick; slot 1 takes the second pick only
  // when slot 0 is also loading, otherwise the first pick.
  assign load0       = avail0 & pick0_found;
  assign load1       = avail0 ? (avail1 & pick1_found) : (avail1 & pick0_found);
  assign load1_index = avail0 ? pick1_index : pick0_index;

  // Per-entry decode of writes, fires and slot loads.
  always_comb begin
    wr_hit   = '0;
    wr_rdy   = '0;
    fire_hit = '0;
    load_hit = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (wr_first_en_i && wr_first_index_i == RS_INDEX_WIDTH'(i)) begin
        wr_hit[i] = 1'b1;
        wr_rdy[i] = wr_first_ready_i | wakeup_i[i];
      end
      if (wr_second_en_i && wr_second_index_i == RS_INDEX_WIDTH'(i)) begin
        wr_hit[i] = 1'b1;
        wr_rdy[i] = wr_second_ready_i | wakeup_i[i];
      end
      fire_hit[i] = (fire0 && slot0_index == RS_INDEX_WIDTH'(i)) ||
                    (fire1 && slot1index_q == RS_INDEX_WIDTH'(i));
      load_hit[i] = (load0 && pick0_index == RS_INDEX_WIDTH'(i)) ||
                    (load1 && load1_index == RS_INDEX_WIDTH'(i));
    end
  end

  // Entry valid/rdy/picked update; flush beats writes, fires and loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_valid  <= '0;
      entry_rdy    <= '0;
      entry_picked <= '0;
    end else if (flush_i) begin
      entry_valid  <= '0;
      entry_picked <= '0;
    end else begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        if (wr_hit[i]) begin
          entry_valid[i]  <= 1'b1;
          entry_picked[i] <= 1'b0;
          entry_rdy[i]    <= wr_rdy[i];
        end else begin
          if (fire_hit[i]) begin
            entry_valid[i]  <= 1'b0;
            entry_picked[i] <= 1'b0;
          end else if (load_hit[i]) begin
            entry_picked[i] <= 1'b1;
          end
          if (entry_valid[i] && wakeup_i[i]) entry_rdy[i] <= 1'b1;
        end
      end
    end
  end

`ifdef RS_AGE_ORDER_EN
  // Saturating age of waiting entries; cleared on write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_age <= '0;
    end else if (!flush_i) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        if (wr_hit[i]) entry_age[i] <= '0;
        else if (entry_valid[i] && !entry_picked[i] && entry_age[i] != '1)
          entry_age[i] <= entry_age[i] + 1'b1;
      end
    end
  end
`endif

  // Issue slots: load on a pick, drop on fire without refill, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_valid  <= 1'b0;
      slot0_index  <= '0;
      slot1_valid  <= 1'b0;
      slot1index_q <= '0;
    end else if (flush_i) begin
      slot0_valid <= 1'b0;
      slot1_valid <= 1'b0;
    end else begin
      if (load0) begin
        slot0_valid <= 1'b1;
        slot0_index <= pick0_index;
      end else if (fire0) begin
        slot0_valid <= 1'b0;
      end
      if (load1) begin
        slot1_valid  <= 1'b1;
        slot1index_q <= load1_index;
      end else if (fire1) begin
        slot1_valid <= 1'b0;
      end
    end
  end

  assign rs_unused_o          = ~entry_valid;
  assign issue_first_valid_o  = slot0_valid;
  assign issue_first_index_o  = slot0_index;
  assign issue_second_valid_o = slot1_valid;
  assign issue_second_index_o = slot1index_q;

  a_wr_first_free: assert property (@(posedge clk) disable iff (!rst_n)
    wr_first_en_i |-> !entry_valid[wr_first_index_i]);
  a_wr_second_free: assert property (@(posedge clk) disable iff (!rst_n)
    wr_second_en_i |-> !entry_valid[wr_second_index_i]);
  a_wr_distinct: assert property (@(posedge clk) disable iff (!rst_n)
    (wr_first_en_i && wr_second_en_i) |-> (wr_first_index_i != wr_second_index_i));

endmodule
